// File: rtl/ct_l2c_flush_pkg.sv
// Shared definitions for the L2C side of the sysio flush handshake.
package ct_l2c_flush_pkg;

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'b00,
    FLUSH_WALK  = 2'b01,
    FLUSH_DRAIN = 2'b10,
    FLUSH_DONE  = 2'b11
  } flush_state_e;

  localparam int FLUSH_IDX_W     = 9;
  localparam int FLUSH_OUTST_MAX = 4;

endpackage

// File: rtl/ct_l2c_flush_resp.sv
// L2C flush responder: walks every set index, waits for the tag pipeline and
// write-back buffer to drain, then answers the sysio four-phase flush request.
module ct_l2c_flush_resp
  import ct_l2c_flush_pkg::*;
#(
  parameter int IDX_W     = FLUSH_IDX_W,
  parameter int OUTST_MAX = FLUSH_OUTST_MAX
) (
  input  logic             sysio_clk,
  input  logic             cpurst_b,
  input  logic             sysio_l2c_flush_req,
  output logic             l2c_sysio_flush_done,
  output logic             l2c_sysio_flush_idle,
  output logic             flush_cmd_vld,
  output logic [IDX_W-1:0] flush_cmd_idx,
  input  logic             flush_cmd_rdy,
  input  logic             flush_cmd_cmplt,
  input  logic             flush_wb_pend
);

  localparam int               CNT_W    = $clog2(OUTST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTST_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  flush_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic             req_drop;
  logic             cmd_acc;
  logic             cnt_dec;
  logic             drain_ok;

  assign flush_cmd_vld = (state == FLUSH_WALK) && (cnt < CNT_MAX);
  assign cmd_acc       = flush_cmd_vld && flush_cmd_rdy;
  // A completion with nothing outstanding is a protocol error; ignore it.
  assign cnt_dec       = flush_cmd_cmplt && (cnt != '0);
  assign drain_ok      = (cnt == '0) && !flush_wb_pend;

  always_ff @(posedge sysio_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cnt <= '0;
    end else if (cmd_acc && !cnt_dec) begin
      cnt <= cnt + 1'b1;
    end else if (!cmd_acc && cnt_dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A request dropped mid-flush still finishes the walk but is never answered.
  always_ff @(posedge sysio_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state                <= FLUSH_IDLE;
      flush_cmd_idx        <= '0;
      req_drop             <= 1'b0;
      l2c_sysio_flush_done <= 1'b0;
    end else begin
      case (state)
        FLUSH_IDLE: begin
          if (sysio_l2c_flush_req) begin
            state         <= FLUSH_WALK;
            flush_cmd_idx <= '0;
            req_drop      <= 1'b0;
          end
        end
        FLUSH_WALK: begin
          if (!sysio_l2c_flush_req) begin
            req_drop <= 1'b1;
          end
          if (cmd_acc) begin
            if (flush_cmd_idx == IDX_LAST) begin
              state <= FLUSH_DRAIN;
            end else begin
              flush_cmd_idx <= flush_cmd_idx + 1'b1;
            end
          end
        end
        FLUSH_DRAIN: begin
          if (!sysio_l2c_flush_req) begin
            req_drop <= 1'b1;
          end
          if (drain_ok) begin
            if (sysio_l2c_flush_req && !req_drop) begin
              state                <= FLUSH_DONE;
              l2c_sysio_flush_done <= 1'b1;
            end else begin
              state <= FLUSH_IDLE;
            end
          end
        end
        FLUSH_DONE: begin
          if (!sysio_l2c_flush_req) begin
            state                <= FLUSH_IDLE;
            l2c_sysio_flush_done <= 1'b0;
          end
        end
        default: state <= FLUSH_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysio_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      l2c_sysio_flush_idle <= 1'b0;
    end else begin
      l2c_sysio_flush_idle <= (state == FLUSH_IDLE) && (cnt == '0) && !flush_wb_pend;
    end
  end

endmodule

// File: tb/tb_ct_l2c_flush_resp.sv
// Scoreboard bench for ct_l2c_flush_resp with a small tag-pipeline model.
module tb_ct_l2c_flush_resp;

  localparam int IDX_W = 2;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  logic             sysio_clk;
  logic             cpurst_b;
  logic             req, done, idle, vld, rdy, cmplt, wb_pend;
  logic [IDX_W-1:0] idx;
  logic             req2, done2, idle2, vld2, rdy2, cmplt2, wb2;
  logic [IDX_W-1:0] idx2;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;
  int   cmplt_lat = 1;
  exp_t exp_q[$];
  int   done_q[$];
  int   due_q[$];

  logic             hold_pend;
  logic [IDX_W-1:0] hold_idx;
  logic             done_d;
  exp_t             e;

  ct_l2c_flush_resp #(.IDX_W(IDX_W), .OUTST_MAX(4)) dut (
    .sysio_clk            (sysio_clk),
    .cpurst_b             (cpurst_b),
    .sysio_l2c_flush_req  (req),
    .l2c_sysio_flush_done (done),
    .l2c_sysio_flush_idle (idle),
    .flush_cmd_vld        (vld),
    .flush_cmd_idx        (idx),
    .flush_cmd_rdy        (rdy),
    .flush_cmd_cmplt      (cmplt),
    .flush_wb_pend        (wb_pend)
  );

  ct_l2c_flush_resp #(.IDX_W(IDX_W), .OUTST_MAX(2)) dut2 (
    .sysio_clk            (sysio_clk),
    .cpurst_b             (cpurst_b),
    .sysio_l2c_flush_req  (req2),
    .l2c_sysio_flush_done (done2),
    .l2c_sysio_flush_idle (idle2),
    .flush_cmd_vld        (vld2),
    .flush_cmd_idx        (idx2),
    .flush_cmd_rdy        (rdy2),
    .flush_cmd_cmplt      (cmplt2),
    .flush_wb_pend        (wb2)
  );

  initial begin
    sysio_clk = 1'b0;
    forever #5 sysio_clk = ~sysio_clk;
  end

  always @(posedge sysio_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event at cycle %0d, expected none", name, cyc);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge sysio_clk);
  endtask

  task automatic push_walk(input int first_cyc, input int step);
    for (int i = 0; i < 4; i++) begin
      exp_t t;
      t.idx = i;
      t.cyc = first_cyc + i * step;
      exp_q.push_back(t);
    end
  endtask

  // Tag pipeline model: owns rdy and cmplt; cmplt returns cmplt_lat cycles after acceptance.
  initial begin
    rdy   = 1'b1;
    cmplt = 1'b0;
    forever begin
      @(negedge sysio_clk);
      rdy   = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      cmplt = 1'b0;
      if (due_q.size() > 0) begin
        if (due_q[0] == cyc) begin
          cmplt = 1'b1;
          void'(due_q.pop_front());
        end
      end
      #1;
      if (!cpurst_b) due_q.delete();
      else if (vld && rdy && cmplt_lat > 0) due_q.push_back(cyc + cmplt_lat);
    end
  end

  // Monitor: pops expected commands and done events as the DUT presents them.
  initial begin
    hold_pend = 1'b0;
    hold_idx  = '0;
    done_d    = 1'b0;
    forever begin
      @(negedge sysio_clk);
      #1;
      if (!cpurst_b) begin
        hold_pend = 1'b0;
        done_d    = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_vld", vld, 1);
          chk("hold_idx", idx, hold_idx);
        end
        hold_pend = vld && !rdy;
        hold_idx  = idx;
        if (vld && rdy) begin
          if (exp_q.size() == 0) begin
            fail_evt("unexpected_accept");
          end else begin
            e = exp_q.pop_front();
            chk("acc_idx", idx, e.idx);
            chk("acc_cyc", cyc, e.cyc);
          end
        end
        if (done && !done_d) begin
          if (done_q.size() == 0) fail_evt("unexpected_done");
          else chk("done_cyc", cyc, done_q.pop_front());
        end
        done_d = done;
      end
    end
  end

  initial begin
    cpurst_b = 1'b0;
    req = 1'b0; wb_pend = 1'b0;
    req2 = 1'b0; rdy2 = 1'b1; cmplt2 = 1'b0; wb2 = 1'b0;

    wait_cyc(2); #1;
    chk("rst_vld", vld, 0);
    chk("rst_done", done, 0);
    chk("rst_idle", idle, 0);
    chk("rst_idx", idx, 0);
    wait_cyc(3); cpurst_b = 1'b1; #1;
    chk("idle_at_release", idle, 0);
    wait_cyc(4); #1;
    chk("idle_after_release", idle, 1);

    // Basic flush
    wait_cyc(10); req = 1'b1; push_walk(11, 1); done_q.push_back(17);
    wait_cyc(20); req = 1'b0;
    wait_cyc(21); #1;
    chk("t1_done_drop", done, 0);
    chk("t1_idle_n1", idle, 0);
    wait_cyc(22); #1;
    chk("t1_idle_n2", idle, 1);

    // Backpressure: rdy high only on cycles divisible by 3
    wait_cyc(38); rdy_mode = 1;
    wait_cyc(40); req = 1'b1; push_walk(42, 3); done_q.push_back(54);
    wait_cyc(58); req = 1'b0;
    wait_cyc(59); rdy_mode = 0; #1;
    chk("t2_done_drop", done, 0);

    // Write-back pending holds off done
    wait_cyc(65); wb_pend = 1'b1;
    wait_cyc(67); #1;
    chk("t3_idle_wb", idle, 0);
    wait_cyc(70); req = 1'b1; push_walk(71, 1); done_q.push_back(106);
    wait_cyc(105); wb_pend = 1'b0;
    wait_cyc(110); req = 1'b0;
    wait_cyc(111); #1;
    chk("t3_done_drop", done, 0);

    // Request dropped mid-walk: full walk, no done
    wait_cyc(130); req = 1'b1; push_walk(131, 1);
    wait_cyc(132); req = 1'b0;
    wait_cyc(137); #1;
    chk("t4_idle_n1", idle, 0);
    wait_cyc(138); #1;
    chk("t4_idle_n2", idle, 1);
    chk("t4_no_done", done, 0);

    // Reset during DRAIN with two commands outstanding
    wait_cyc(150); cmplt_lat = 3;
    wait_cyc(160); req = 1'b1; push_walk(161, 1);
    wait_cyc(166); #2; cpurst_b = 1'b0; req = 1'b0; #1;
    chk("t5_rst_vld", vld, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_idle", idle, 0);
    chk("t5_rst_idx", idx, 0);
    wait_cyc(167); cmplt_lat = 1;
    wait_cyc(170); cpurst_b = 1'b1; #1;
    chk("t5_idle_release", idle, 0);
    wait_cyc(171); #1;
    chk("t5_idle_after", idle, 1);
    wait_cyc(180); req = 1'b1; push_walk(181, 1); done_q.push_back(187);
    wait_cyc(190); req = 1'b0;
    wait_cyc(191); #1;
    chk("t5_done_drop", done, 0);
    wait_cyc(192); #1;
    chk("t5_idle_end", idle, 1);

    // OUTST_MAX=2 instance: credit limit, simultaneous accept and cmplt
    wait_cyc(200); req2 = 1'b1;
    wait_cyc(201); #1; chk("t6_vld_c201", vld2, 1); chk("t6_idx_c201", idx2, 0);
    wait_cyc(202); #1; chk("t6_vld_c202", vld2, 1); chk("t6_idx_c202", idx2, 1);
    wait_cyc(203); #1; chk("t6_vld_full", vld2, 0);
    wait_cyc(204); cmplt2 = 1'b1; #1; chk("t6_vld_c204", vld2, 0);
    wait_cyc(205); #1; chk("t6_vld_reopen", vld2, 1); chk("t6_idx_c205", idx2, 2);
    wait_cyc(206); cmplt2 = 1'b0; #1; chk("t6_vld_simul", vld2, 1); chk("t6_idx_c206", idx2, 3);
    wait_cyc(207); cmplt2 = 1'b1; #1; chk("t6_vld_drain", vld2, 0);
    wait_cyc(208); #1; chk("t6_done_c208", done2, 0);
    wait_cyc(209); cmplt2 = 1'b0; #1; chk("t6_done_c209", done2, 0);
    wait_cyc(210); #1; chk("t6_done_c210", done2, 1);
    wait_cyc(212); req2 = 1'b0;
    wait_cyc(213); #1; chk("t6_done_drop", done2, 0);
    wait_cyc(214); #1; chk("t6_idle", idle2, 1);

    // Stray cmplt with nothing outstanding must not wrap the counter
    wait_cyc(216); cmplt2 = 1'b1;
    wait_cyc(217); cmplt2 = 1'b0; req2 = 1'b1;
    wait_cyc(218); #1;
    chk("t7_idle_no_wrap", idle2, 1);
    chk("t7_vld_no_wrap", vld2, 1);
    chk("t7_idx", idx2, 0);
    req2 = 1'b0;

    wait_cyc(240); #1;
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
